// File: rtl/register_file_pkg.sv
// Shared definitions for the TinyCPU architectural register file.
//   rf_state_e : state of the clear sequencer (CLEAR sweeps the array, RUN serves ports)
//   RF_*       : default geometry of the architectural register file
package register_file_pkg;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;

  typedef enum logic {
    RF_STATE_CLEAR = 1'b0,
    RF_STATE_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_clear_sequencer.sv
// Clear sequencer for the register file.
// After reset or soft_clear it walks idx over every register, requesting a write of 0
// each cycle, then enters RUN and raises ready.
//   clk, rst_n   : clock, asynchronous active-low reset
//   soft_clear   : 1-cycle pulse, restart the sweep at index 0
//   run          : 1 while in RUN (ports live)
//   ready        : registered copy of "in RUN"
//   clear_we     : sweep write request to the array write mux
//   clear_addr   : sweep write index
module rf_clear_sequencer
  import register_file_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_clear,
  output logic              run,
  output logic              ready,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr
);

  // One extra bit so the terminal index never aliases with 0.
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  rf_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ready_q, ready_d;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_STATE_CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic.
  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_STATE_CLEAR: begin
        if (soft_clear) begin
          idx_d = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = RF_STATE_RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RF_STATE_RUN: begin
        if (soft_clear) begin
          state_d = RF_STATE_CLEAR;
          idx_d   = '0;
        end
      end
    endcase
    ready_d = (state_d == RF_STATE_RUN);
  end

  // Outputs.
  always_comb begin
    run        = (state_q == RF_STATE_RUN);
    ready      = ready_q;
    clear_we   = (state_q == RF_STATE_CLEAR);
    clear_addr = idx_q[ADDR_W-1:0];
  end

endmodule

// File: rtl/register_file.sv
// TinyCPU architectural register file: one write port, two registered read ports with
// write-first bypass, and a clear sweep after reset or soft_clear.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   soft_clear                 : 1-cycle pulse, restart the clear sweep
//   write_address/_data/_enable: write port (ignored while clearing)
//   read_reg_0/1               : read indices, sampled every edge
//   read_data_0/1              : read data, 1-cycle latency, held until the next edge
//   ready                      : 1 when the sweep is done and the ports are live
module register_file
  import register_file_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_clear,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] read_reg_0,
  input  logic [ADDR_W-1:0] read_reg_1,
  output logic [DATA_W-1:0] read_data_0,
  output logic [DATA_W-1:0] read_data_1,
  output logic              ready
);

  logic              run;
  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;

  rf_clear_sequencer #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .soft_clear (soft_clear),
    .run        (run),
    .ready      (ready),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  logic [DATA_W-1:0] regs [0:NUM_REGS-1];

  logic              port_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] read_data_0_q, read_data_0_d;
  logic [DATA_W-1:0] read_data_1_q, read_data_1_d;

  // Read value for one port: zero register first, then write-first bypass, then array.
  function automatic logic [DATA_W-1:0] port_value(
    input logic              live,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored
  );
    if (!live)                          return '0;
    if ((ZERO_REG != 0) && (ra == '0))  return '0;
    if (we && (ra == wa))               return wd;
    return stored;
  endfunction

  always_comb begin
    // A port write is dropped while clearing, when soft_clear arrives, and to r0 when
    // r0 is hard-wired to zero.
    port_we = run && write_enable && !soft_clear &&
              !((ZERO_REG != 0) && (write_address == '0));

    // The sweep only runs outside RUN, so it never competes with a port write.
    mem_we    = clear_we || port_we;
    mem_addr  = clear_we ? clear_addr : write_address;
    mem_wdata = clear_we ? '0 : write_data;

    read_data_0_d = port_value(run, port_we, write_address, write_data,
                               read_reg_0, regs[read_reg_0]);
    read_data_1_d = port_value(run, port_we, write_address, write_data,
                               read_reg_1, regs[read_reg_1]);
  end

  // NOTE: the array has no reset; the clear sweep zeroes it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) regs[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_0_q <= '0;
      read_data_1_q <= '0;
    end else begin
      read_data_0_q <= read_data_0_d;
      read_data_1_q <= read_data_1_d;
    end
  end

  assign read_data_0 = read_data_0_q;
  assign read_data_1 = read_data_1_q;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file (ZERO_REG=1). The driver applies one input set per
// cycle, advances a behavioural model and queues the expected outputs; the monitor pops
// and compares after each rising edge.
module tb_register_file;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int ZERO_REG = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              soft_clear = 1'b0;
  logic [ADDR_W-1:0] write_address = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic              write_enable = 1'b0;
  logic [ADDR_W-1:0] read_reg_0 = '0;
  logic [ADDR_W-1:0] read_reg_1 = '0;
  logic [DATA_W-1:0] read_data_0;
  logic [DATA_W-1:0] read_data_1;
  logic              ready;

  register_file #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .soft_clear    (soft_clear),
    .write_address (write_address),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .read_reg_0    (read_reg_0),
    .read_reg_1    (read_reg_1),
    .read_data_0   (read_data_0),
    .read_data_1   (read_data_1),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;
    logic              rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic rst_req  = 1'b0;

  // Behavioural model: register contents, whether ports are live, cycles of sweep left.
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  bit                m_run;
  int                m_left;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Entering CLEAR: nothing is observable until the sweep ends, so contents read as zero.
  function automatic void model_clear();
    m_run  = 1'b0;
    m_left = NUM_REGS;
    foreach (m_regs[i]) m_regs[i] = '0;
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  function automatic exp_t model_edge();
    exp_t e;
    bit   we_eff;
    e = '0;
    if (!rst_n) begin
      model_clear();
      return e;
    end
    if (!m_run) begin
      if (soft_clear) m_left = NUM_REGS;
      else begin
        m_left--;
        if (m_left == 0) m_run = 1'b1;
      end
    end else begin
      we_eff = write_enable && !soft_clear && !(ZERO_REG != 0 && write_address == 0);
      e.rd0  = (we_eff && read_reg_0 == write_address) ? write_data : m_regs[read_reg_0];
      e.rd1  = (we_eff && read_reg_1 == write_address) ? write_data : m_regs[read_reg_1];
      if (we_eff) m_regs[write_address] = write_data;
      if (soft_clear) model_clear();
    end
    e.rdy = m_run;
    return e;
  endfunction

  task automatic step(input logic sc, input logic we, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] r0,
                      input logic [ADDR_W-1:0] r1);
    @(negedge clk);
    #1;
    rst_n         = rst_req;
    soft_clear    = sc;
    write_enable  = we;
    write_address = wa;
    write_data    = wd;
    read_reg_0    = r0;
    read_reg_1    = r1;
    exp_q.push_back(model_edge());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  // Asynchronous reset between edges: outputs must drop immediately.
  task automatic async_reset();
    @(negedge clk);
    #1;
    rst_req = 1'b0;
    rst_n   = 1'b0;
    model_clear();
    #1;
    check("async_rd0", read_data_0, '0);
    check("async_rd1", read_data_1, '0);
    check("async_ready", {31'b0, ready}, '0);
  endtask

  // Monitor: compare after every edge that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("read_data_0", read_data_0, e.rd0);
        check("read_data_1", read_data_1, e.rd1);
        check("ready", {31'b0, ready}, {31'b0, e.rdy});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    model_clear();
    #1 rst_n = 1'b0;
    rst_req = 1'b0;
    idle(3);

    // Release: 32 sweep cycles, ready on the 33rd, then every register reads 0.
    rst_req = 1'b1;
    idle(NUM_REGS);
    for (int i = 0; i < NUM_REGS; i++)
      step(1'b0, 1'b0, '0, '0, ADDR_W'(i), ADDR_W'(NUM_REGS - 1 - i));

    // Write then read back one cycle later.
    step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
    step(1'b0, 1'b0, '0, '0, 5'd5, 5'd5);

    // Both ports bypass the same write.
    step(1'b0, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
    step(1'b0, 1'b0, '0, '0, 5'd7, 5'd5);

    // r0 is hard-wired to zero: same-cycle and next-cycle reads.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    step(1'b0, 1'b0, '0, '0, 5'd0, 5'd7);

    // soft_clear drops its own write and any write during the sweep.
    step(1'b0, 1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd0);
    step(1'b1, 1'b1, 5'd4, 32'h0000_0001, 5'd3, 5'd4);
    step(1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9);
    idle(NUM_REGS - 1);
    step(1'b0, 1'b0, '0, '0, 5'd3, 5'd4);
    step(1'b0, 1'b0, '0, '0, 5'd9, 5'd5);

    // soft_clear during CLEAR restarts the full sweep.
    step(1'b1, 1'b0, '0, '0, '0, '0);
    idle(5);
    step(1'b1, 1'b0, '0, '0, '0, '0);
    idle(NUM_REGS + 1);

    // Reset mid-run with live data, then mid-sweep at idx=10.
    step(1'b0, 1'b1, 5'd2, 32'h0000_0011, 5'd0, 5'd0);
    step(1'b0, 1'b0, '0, '0, 5'd2, 5'd2);
    async_reset();
    idle(2);
    rst_req = 1'b1;
    idle(10);
    async_reset();
    idle(2);
    rst_req = 1'b1;
    idle(NUM_REGS + 1);
    step(1'b0, 1'b0, '0, '0, 5'd2, 5'd5);

    // Randomised traffic; narrow address range half the time to provoke bypass.
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] wa, r0, r1;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      wa = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      r0 = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      r1 = narrow ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0), wa,
           DATA_W'($urandom), r0, r1);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
